// File: rtl/mc_main_controller_if.sv
// Control bus between the multi-cycle main controller and the datapath.
// Carries the IR opcode and ALU zero flag into the controller, and all
// datapath enables/selects, status pulses and debug/count values out.
//   master : the controller (drives controls, reads opcode/zero)
//   slave  : the datapath side (drives opcode/zero, reads controls)
interface mc_main_controller_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, zero,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_done, illegal_op, retired, state_dbg
  );

  modport slave (
    output opcode, zero,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_done, illegal_op, retired, state_dbg
  );
endinterface

// File: rtl/mc_main_controller.sv
// Multi-cycle MIPS main control FSM.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath enables and the 2-bit ALUOp, counts retired
// instructions and pulses illegal_op for unsupported opcodes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : controller side of mc_main_controller_if (opcode/zero in,
//           datapath controls, instr_done, illegal_op, retired, state_dbg out)
module mc_main_controller #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mc_main_controller_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;

  // Decoded (ungated) outputs of the current state.
  logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_src_s;
  logic       done_s;
  logic       op_legal;

  always_comb begin
    op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
               (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
               (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI);
  end

  // Next-state sequencing and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      if (done_s) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default:      state_q <= S_FETCH;
          endcase
        end
        // The IR is frozen outside FETCH, so MEMADR sees the same opcode
        // DECODE did; anything other than LW/SW here cannot occur, but
        // recover to FETCH rather than guess.
        S_MEMADR: begin
          if (bus.opcode == OP_LW)      state_q <= S_MEMRD;
          else if (bus.opcode == OP_SW) state_q <= S_MEMWR;
          else                          state_q <= S_FETCH;
        end
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_src_s        = 2'b00;
    done_s          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
        pc_write_s  = 1'b1;
      end
      S_DECODE: alu_src_b_s = 2'b11;
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        done_s       = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        done_s      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        done_s      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_src_s        = 2'b01;
        done_s          = 1'b1;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'b10;
        done_s     = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables and pulses are masked while reset is held so the datapath sees
  // no strobe even though the state already reads FETCH; selects pass through.
  always_comb begin
    bus.pc_write      = pc_write_s      & rst_n;
    bus.pc_write_cond = pc_write_cond_s & rst_n;
    bus.mem_read      = mem_read_s      & rst_n;
    bus.mem_write     = mem_write_s     & rst_n;
    bus.ir_write      = ir_write_s      & rst_n;
    bus.reg_write     = reg_write_s     & rst_n;
    bus.instr_done    = done_s          & rst_n;
    bus.illegal_op    = (state_q == S_DECODE) & ~op_legal & rst_n;
    bus.i_or_d        = i_or_d_s;
    bus.mem_to_reg    = mem_to_reg_s;
    bus.reg_dst       = reg_dst_s;
    bus.alu_src_a     = alu_src_a_s;
    bus.alu_src_b     = alu_src_b_s;
    bus.alu_op        = alu_op_s;
    bus.pc_src        = pc_src_s;
    bus.retired       = retired_q;
    bus.state_dbg     = state_q;
  end

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: a driver issues instructions and pushes the
// expected per-cycle controller response into a queue; a monitor pops and
// compares on every falling edge.
module tb_mc_main_controller;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_controller_if #(.CNT_W(CNT_W)) bus ();
  mc_main_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]       st;
    logic [17:0]      ctl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  typedef int iq_t[$];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_ret = 0;

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  // State path an instruction walks, by opcode.
  function automatic iq_t seq_of(logic [5:0] op);
    iq_t s;
    case (op)
      OP_LW:    s = '{0, 1, 2, 3, 4};
      OP_SW:    s = '{0, 1, 2, 5};
      OP_RTYPE: s = '{0, 1, 6, 7};
      OP_ADDI:  s = '{0, 1, 10, 11};
      OP_BEQ:   s = '{0, 1, 8};
      OP_J:     s = '{0, 1, 9};
      default:  s = '{0, 1};
    endcase
    return s;
  endfunction

  // Expected control word for a state, packed in the monitor's order.
  function automatic logic [17:0] ctl_of(int st, bit ill, bit in_rst);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, dn, il;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, dn, il} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; iod = 1; dn = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      9:  begin pw = 1; ps = 2'b10; dn = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    if (in_rst) {pw, pwc, mr, mw, irw, rw, dn, il} = '0;
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, dn, il};
  endfunction

  task automatic push_rst();
    exp_t e;
    e.st = 4'd0; e.ctl = ctl_of(0, 1'b0, 1'b1); e.ret = '0;
    q.push_back(e);
  endtask

  // Called at posedge+1 with the DUT in FETCH. rst_at >= 0 asserts reset
  // during that cycle of the instruction and holds it for 3 cycles.
  task automatic run_instr(input logic [5:0] op, input int zv, input int rst_at);
    iq_t s;
    exp_t e;
    s = seq_of(op);
    for (int k = 0; k < s.size(); k++) begin
      bus.opcode = (k <= 2) ? op : 6'($urandom);
      bus.zero   = (zv < 0) ? 1'($urandom) : 1'(zv);
      if (k == rst_at) begin
        rst_n = 1'b0;
        model_ret = 0;
        for (int r = 0; r < 3; r++) begin
          push_rst();
          @(posedge clk); #1;
        end
        rst_n = 1'b1;
        return;
      end
      e.st  = 4'(s[k]);
      e.ctl = ctl_of(s[k], (s[k] == 1) && !is_legal(op), 1'b0);
      e.ret = CNT_W'(model_ret);
      q.push_back(e);
      if (e.ctl[1]) model_ret = (model_ret + 1) % (1 << CNT_W);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: one comparison per cycle that has an expectation queued.
  always @(negedge clk) begin
    exp_t e;
    logic [17:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
             bus.pc_src, bus.instr_done, bus.illegal_op};
      n_cmp++;
      if (bus.state_dbg !== e.st || act !== e.ctl || bus.retired !== e.ret) begin
        n_err++;
        $display("FAIL cycle_ctrl t=%0t: got state=%0d ctl=%b retired=%0d, expected state=%0d ctl=%b retired=%0d",
                 $time, bus.state_dbg, act, bus.retired, e.st, e.ctl, e.ret);
      end
    end
  end

  initial begin
    logic [5:0] legal [6];
    logic [5:0] op;
    int wait_cyc;
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    bus.opcode = 6'd0;
    bus.zero   = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      bus.opcode = 6'($urandom);
      push_rst();
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    run_instr(OP_LW, -1, -1);
    run_instr(OP_RTYPE, -1, -1);
    run_instr(OP_SW, -1, -1);
    run_instr(OP_BEQ, 1, -1);
    run_instr(OP_BEQ, 0, -1);
    run_instr(6'b111111, -1, -1);
    run_instr(OP_ADDI, -1, -1);
    for (int i = 0; i < 16; i++) run_instr(OP_J, -1, -1);
    run_instr(OP_LW, -1, 3);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 5)];
      run_instr(op, -1, -1);
    end
    run_instr(OP_LW, -1, 1);
    run_instr(OP_ADDI, -1, -1);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
